// File: rtl/cache_mem_responder_pkg.sv
// Shared encodings for the cache memory-side responder: access types and FSM states.
// Unsupported access types fall back to word behaviour, so only LINE needs a predicate.
package cache_mem_responder_pkg;

  localparam logic [2:0] MEM_TYPE_BYTE = 3'b000;
  localparam logic [2:0] MEM_TYPE_HALF = 3'b001;
  localparam logic [2:0] MEM_TYPE_WORD = 3'b010;
  localparam logic [2:0] MEM_TYPE_LINE = 3'b100;

  localparam logic [1:0] MEMRSP_STATE_IDLE    = 2'd0;
  localparam logic [1:0] MEMRSP_STATE_RD_WAIT = 2'd1;
  localparam logic [1:0] MEMRSP_STATE_RD_BEAT = 2'd2;
  localparam logic [1:0] MEMRSP_STATE_WR_BUSY = 2'd3;

  function automatic logic mem_is_line(input logic [2:0] t);
    return t == MEM_TYPE_LINE;
  endfunction

endpackage

// File: rtl/cache_mem_store.sv
// Word-addressed backing array: one synchronous read port (1 cycle), one write port
// taking either a whole 4-word line or a single byte-enabled word. Array is not reset.
module cache_mem_store
  import cache_mem_responder_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              re_i,
  input  logic [MEM_AW-1:0] raddr_i,
  output logic [31:0]       rdata_o,
  input  logic              we_i,
  input  logic              wline_i,
  input  logic [MEM_AW-1:0] waddr_i,
  input  logic [127:0]      wdata_i,
  input  logic [3:0]        wstrb_i
);

  logic [31:0] mem [2**MEM_AW];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      if (wline_i) begin
        for (int k = 0; k < 4; k++) begin
          mem[{waddr_i[MEM_AW-1:2], 2'(k)}] <= wdata_i[32*k +: 32];
        end
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (wstrb_i[b]) mem[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // The read register doubles as the responder's ret_data output, hence the reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder for cache refill/write-back: line reads return as a 4-beat burst
// after RD_LATENCY cycles, writes commit at accept and hold the port busy WR_LATENCY cycles.
module cache_mem_responder
  import cache_mem_responder_pkg::*;
#(
  parameter int MEM_AW     = 12,
  parameter int RD_LATENCY = 2,
  parameter int WR_LATENCY = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [2:0]   wr_size,
  input  logic [127:0] wr_data,
  output logic         wr_rdy
);

  localparam logic [3:0] RD_WAIT_INIT = (RD_LATENCY > 1) ? 4'(RD_LATENCY - 2) : 4'd0;
  localparam logic [3:0] WR_BUSY_INIT = 4'(WR_LATENCY - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [1:0]        beat_q, beat_d;
  logic              line_q, line_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              rdy_q, rdy_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;

  logic              rd_line, wr_line;
  logic [MEM_AW-1:0] rd_idx_in;
  logic              issue, issue_last, we;
  logic [MEM_AW-1:0] issue_idx;
  logic              unused_bits;

  assign rd_line   = mem_is_line(rd_type);
  assign wr_line   = mem_is_line(wr_type);
  assign rd_idx_in = rd_line ? {rd_addr[MEM_AW+1:4], 2'b00} : rd_addr[MEM_AW+1:2];

  // "issue" launches the store read whose data appears as a beat in the next cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    line_d     = line_q;
    addr_d     = addr_q;
    rdy_d      = 1'b0;
    issue      = 1'b0;
    issue_idx  = addr_q;
    issue_last = 1'b0;
    we         = 1'b0;
    case (state_q)
      MEMRSP_STATE_IDLE: begin
        if (rdy_q && wr_req) begin
          we      = 1'b1;
          state_d = MEMRSP_STATE_WR_BUSY;
          cnt_d   = WR_BUSY_INIT;
        end else if (rdy_q && rd_req) begin
          line_d = rd_line;
          addr_d = rd_idx_in;
          if (RD_LATENCY == 1) begin
            issue      = 1'b1;
            issue_idx  = rd_idx_in;
            issue_last = !rd_line;
            beat_d     = 2'd1;
            state_d    = MEMRSP_STATE_RD_BEAT;
          end else begin
            cnt_d   = RD_WAIT_INIT;
            state_d = MEMRSP_STATE_RD_WAIT;
          end
        end else begin
          rdy_d = 1'b1;
        end
      end
      MEMRSP_STATE_RD_WAIT: begin
        if (cnt_q == 4'd0) begin
          issue      = 1'b1;
          issue_idx  = addr_q;
          issue_last = !line_q;
          beat_d     = 2'd1;
          state_d    = MEMRSP_STATE_RD_BEAT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      MEMRSP_STATE_RD_BEAT: begin
        if (last_q) begin
          state_d = MEMRSP_STATE_IDLE;
          rdy_d   = 1'b1;
        end else begin
          issue      = 1'b1;
          issue_idx  = {addr_q[MEM_AW-1:2], beat_q};
          issue_last = (beat_q == 2'd3);
          beat_d     = beat_q + 2'd1;
        end
      end
      MEMRSP_STATE_WR_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_d = MEMRSP_STATE_IDLE;
          rdy_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = MEMRSP_STATE_IDLE;
    endcase
    valid_d = issue;
    last_d  = issue_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MEMRSP_STATE_IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      line_q  <= 1'b0;
      addr_q  <= '0;
      rdy_q   <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      addr_q  <= addr_d;
      rdy_q   <= rdy_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  cache_mem_store #(.MEM_AW(MEM_AW)) u_store (
    .clk     (clk),
    .reset   (reset),
    .re_i    (issue),
    .raddr_i (issue_idx),
    .rdata_o (ret_data),
    .we_i    (we),
    .wline_i (wr_line),
    .waddr_i (wr_addr[MEM_AW+1:2]),
    .wdata_i (wr_data),
    .wstrb_i (wr_wstrb)
  );

  assign rd_rdy    = rdy_q;
  assign wr_rdy    = rdy_q;
  assign ret_valid = valid_q;
  assign ret_last  = last_q;

  assign unused_bits = ^{wr_size, rd_addr[31:MEM_AW+2], rd_addr[1:0],
                         wr_addr[31:MEM_AW+2], wr_addr[1:0]};

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: timeline model (expected beats per cycle, ready-from cycle)
// plus directed literal checks, a fast-latency instance, and a randomized phase.
module tb_cache_mem_responder;

  localparam int AW = 12;
  localparam int L  = 2;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic         rd_req = 1'b0, wr_req = 1'b0;
  logic [2:0]   rd_type = '0, wr_type = '0, wr_size = '0;
  logic [31:0]  rd_addr = '0, wr_addr = '0;
  logic [3:0]   wr_wstrb = '0;
  logic [127:0] wr_data = '0;
  logic         rd_rdy, wr_rdy, ret_valid, ret_last;
  logic [31:0]  ret_data;

  logic         f_rd_req = 1'b0, f_wr_req = 1'b0;
  logic [2:0]   f_rd_type = '0, f_wr_type = '0;
  logic [31:0]  f_rd_addr = '0, f_wr_addr = '0;
  logic [127:0] f_wr_data = '0;
  logic         f_rd_rdy, f_wr_rdy, f_ret_valid, f_ret_last;
  logic [31:0]  f_ret_data;

  cache_mem_responder #(.MEM_AW(AW), .RD_LATENCY(L), .WR_LATENCY(W)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_size(wr_size), .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  cache_mem_responder #(.MEM_AW(AW), .RD_LATENCY(1), .WR_LATENCY(1)) dut_fast (
    .clk(clk), .reset(reset), .rd_req(f_rd_req), .rd_type(f_rd_type), .rd_addr(f_rd_addr),
    .rd_rdy(f_rd_rdy), .ret_valid(f_ret_valid), .ret_last(f_ret_last), .ret_data(f_ret_data),
    .wr_req(f_wr_req), .wr_type(f_wr_type), .wr_addr(f_wr_addr), .wr_wstrb(4'hF),
    .wr_size(3'd0), .wr_data(f_wr_data), .wr_rdy(f_wr_rdy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h (cycle t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: cycle k is the interval after the k-th post-reset edge.
  int  cyc = 0;
  int  free_at = 0;
  bit  rst_seen = 1'b1;
  int  wr_acc = -1, rd_acc = -1;
  logic [31:0] mmem [int];
  logic [31:0] exp_d [int];
  bit          exp_l [int];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_d.delete();
      exp_l.delete();
      rst_seen = 1'b1;
    end else begin
      cyc = cyc + 1;
      if (rst_seen) begin
        rst_seen = 1'b0;
        free_at  = cyc;
      end else if (cyc - 1 >= free_at) begin
        if (wr_req) begin
          if (wr_type == 3'b100) begin
            for (int k = 0; k < 4; k++) mmem[int'(wr_addr[13:4]) * 4 + k] = wr_data[32*k +: 32];
          end else begin
            int w;
            logic [31:0] v;
            w = int'(wr_addr[13:2]);
            v = mmem.exists(w) ? mmem[w] : 32'hx;
            for (int b = 0; b < 4; b++) if (wr_wstrb[b]) v[8*b +: 8] = wr_data[8*b +: 8];
            mmem[w] = v;
          end
          free_at = cyc + W;
          wr_acc  = cyc;
        end else if (rd_req) begin
          int base, nb;
          if (rd_type == 3'b100) begin base = int'(rd_addr[13:4]) * 4; nb = 4; end
          else begin base = int'(rd_addr[13:2]); nb = 1; end
          for (int b = 0; b < nb; b++) begin
            exp_d[cyc + L - 1 + b] = mmem.exists(base + b) ? mmem[base + b] : 32'hx;
            exp_l[cyc + L - 1 + b] = (b == nb - 1);
          end
          free_at = cyc + L - 1 + nb;
          rd_acc  = cyc;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check("rst_rd_rdy", 128'(rd_rdy), 128'(0));
      check("rst_wr_rdy", 128'(wr_rdy), 128'(0));
      check("rst_ret_valid", 128'(ret_valid), 128'(0));
      check("rst_ret_last", 128'(ret_last), 128'(0));
      check("rst_ret_data", 128'(ret_data), 128'(0));
    end else begin
      bit exp_rdy, ev;
      exp_rdy = !rst_seen && (cyc >= free_at);
      ev = exp_d.exists(cyc);
      check("rd_rdy", 128'(rd_rdy), 128'(exp_rdy));
      check("wr_rdy", 128'(wr_rdy), 128'(exp_rdy));
      check("ret_valid", 128'(ret_valid), 128'(ev));
      check("ret_last", 128'(ret_last), 128'(ev ? exp_l[cyc] : 1'b0));
      if (ev && !$isunknown(exp_d[cyc])) check("ret_data", 128'(ret_data), 128'(exp_d[cyc]));
    end
  end

  int          mon_cyc [$];
  logic [31:0] mon_dat [$];
  bit          mon_last[$];
  bit          seen_last = 1'b0;

  always @(negedge clk) begin
    if (!reset && ret_valid) begin
      mon_cyc.push_back(cyc);
      mon_dat.push_back(ret_data);
      mon_last.push_back(ret_last);
      if (ret_last) seen_last = 1'b1;
    end
  end

  task automatic mon_clear();
    mon_cyc.delete(); mon_dat.delete(); mon_last.delete();
  endtask

  task automatic do_write(input logic [2:0] t, input logic [31:0] a, input logic [127:0] d,
                          input logic [3:0] s, output int e);
    wr_req = 1'b1; wr_type = t; wr_addr = a; wr_data = d; wr_wstrb = s;
    wr_size = 3'($urandom_range(0, 7));
    e = -1;
    for (int i = 0; i < 40 && e < 0; i++) begin
      @(posedge clk); #1;
      if (wr_acc == cyc) e = cyc;
    end
    wr_req = 1'b0;
    check("wr_accepted", 128'(e >= 0), 128'(1));
  endtask

  task automatic do_read(input logic [2:0] t, input logic [31:0] a, output int e);
    rd_req = 1'b1; rd_type = t; rd_addr = a;
    e = -1;
    for (int i = 0; i < 40 && e < 0; i++) begin
      @(posedge clk); #1;
      if (rd_acc == cyc) e = cyc;
    end
    rd_req = 1'b0;
    check("rd_accepted", 128'(e >= 0), 128'(1));
  endtask

  task automatic check_beats(input string nm, input int e0, input int nb, input logic [127:0] line);
    check({nm, "_count"}, 128'(mon_cyc.size()), 128'(nb));
    for (int b = 0; b < nb && b < mon_cyc.size(); b++) begin
      check({nm, "_data"}, 128'(mon_dat[b]), 128'(line[32*b +: 32]));
      check({nm, "_cycle"}, 128'(mon_cyc[b]), 128'(e0 + L - 1 + b));
      check({nm, "_last"}, 128'(mon_last[b]), 128'(b == nb - 1));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e, ew, er, lowc;
    logic [127:0] d3, d6;
    logic [31:0]  a;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("rdy_after_reset", 128'({rd_rdy, wr_rdy}), 128'(2'b11));

    // Fast instance: RD_LATENCY=1, WR_LATENCY=1.
    @(negedge clk);
    f_wr_req = 1'b1; f_wr_type = 3'b100; f_wr_addr = 32'h40;
    f_wr_data = 128'h0F0F_0003_0F0F_0002_0F0F_0001_0F0F_0000;
    check("fast_wr_rdy_idle", 128'(f_wr_rdy), 128'(1));
    @(posedge clk); #1; f_wr_req = 1'b0;
    @(negedge clk); check("fast_wr_busy", 128'(f_wr_rdy), 128'(0));
    @(negedge clk); check("fast_wr_back", 128'(f_wr_rdy), 128'(1));
    f_rd_req = 1'b1; f_rd_type = 3'b100; f_rd_addr = 32'h48;
    @(posedge clk); #1; f_rd_req = 1'b0;
    for (int b = 0; b < 4; b++) begin
      @(negedge clk);
      check("fast_beat_valid", 128'(f_ret_valid), 128'(1));
      check("fast_beat_data", 128'(f_ret_data), 128'(32'h0F0F_0000 + 32'(b)));
      check("fast_beat_last", 128'(f_ret_last), 128'(b == 3));
    end
    @(negedge clk);
    check("fast_done_valid", 128'(f_ret_valid), 128'(0));
    check("fast_done_rdy", 128'(f_rd_rdy), 128'(1));
    @(posedge clk); #1;

    // Line write then line read (critical word at 0x10C must not reorder beats).
    do_write(3'b100, 32'h100, 128'h4444_4444_3333_3333_2222_2222_1111_1111, 4'h0, e);
    lowc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (wr_rdy) break;
      lowc++;
    end
    check("wr_rdy_low_cycles", 128'(lowc), 128'(4));
    mon_clear();
    do_read(3'b100, 32'h10C, e);
    repeat (L + 4) @(posedge clk); #1;
    check_beats("line_read", e, 4, 128'h4444_4444_3333_3333_2222_2222_1111_1111);

    // Strobed word write then single read.
    do_write(3'b010, 32'h104, 128'hAABB_CCDD, 4'b0101, e);
    mon_clear();
    do_read(3'b010, 32'h104, e);
    repeat (L + 3) @(posedge clk); #1;
    check_beats("strobe_read", e, 1, 128'h22BB_22DD);

    // Simultaneous requests on the same line: write wins, read sees new data.
    d3 = 128'hDDDD_0003_CCCC_0002_BBBB_0001_AAAA_0000;
    mon_clear();
    ew = -1; er = -1;
    wr_req = 1'b1; wr_type = 3'b100; wr_addr = 32'h200; wr_data = d3; wr_wstrb = 4'h0;
    rd_req = 1'b1; rd_type = 3'b100; rd_addr = 32'h208;
    for (int i = 0; i < 40 && er < 0; i++) begin
      @(posedge clk); #1;
      if (wr_acc == cyc) begin ew = cyc; wr_req = 1'b0; end
      if (rd_acc == cyc) er = cyc;
    end
    rd_req = 1'b0; wr_req = 1'b0;
    check("simul_wr_first", 128'(ew >= 0 && er > ew), 128'(1));
    check("simul_rd_gap", 128'(er - ew), 128'(W + 1));
    repeat (L + 4) @(posedge clk); #1;
    check_beats("simul_read", er, 4, d3);

    // Aliasing: bit 14 lies above the 16 KiB store.
    d6 = 128'h0606_0004_0606_0003_0606_0002_0606_0001;
    do_write(3'b100, 32'h0000_4010, d6, 4'h0, e);
    mon_clear();
    do_read(3'b100, 32'h0000_0010, e);
    repeat (L + 4) @(posedge clk); #1;
    check_beats("alias_read", e, 4, d6);

    // Reset during the second beat truncates the burst.
    mon_clear();
    seen_last = 1'b0;
    do_read(3'b100, 32'h100, e);
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check("trunc_valid", 128'(ret_valid), 128'(0));
    check("trunc_last", 128'(ret_last), 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("trunc_rdy_after", 128'(rd_rdy), 128'(1));
    repeat (4) @(posedge clk); #1;
    check("trunc_no_last", 128'(seen_last), 128'(0));
    check("trunc_beats", 128'(mon_cyc.size()), 128'(1));

    // Randomized phase over a 64-word window with random alias/upper address bits.
    for (int ln = 0; ln < 16; ln++)
      do_write(3'b100, 32'(ln * 16), {$urandom(), $urandom(), $urandom(), $urandom()}, 4'h0, e);
    for (int i = 0; i < 600; i++) begin
      a = $urandom(); a[13:8] = 6'd0;
      wr_req   = ($urandom_range(0, 9) < 3);
      wr_type  = 3'($urandom_range(0, 7));
      wr_addr  = a;
      wr_wstrb = 4'($urandom_range(0, 15));
      wr_size  = 3'($urandom_range(0, 7));
      wr_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
      a = $urandom(); a[13:8] = 6'd0;
      rd_req  = ($urandom_range(0, 9) < 5);
      rd_type = 3'($urandom_range(0, 7));
      rd_addr = a;
      @(posedge clk); #1;
    end
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
